// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpio_pkg
// Brief   : Shared constants for the gpio_port peripheral: register window
//           offsets, default widths and reset values.
// Revision: 1.0 - initial release
// ============================================================================
package gpio_pkg;

    localparam int GPIO_DATA_WIDTH = 32;
    localparam int GPIO_ADDR_WIDTH = 3;

    localparam int GPIO_OFF_OUT       = 0;
    localparam int GPIO_OFF_DIR       = 1;
    localparam int GPIO_OFF_IN        = 2;
    localparam int GPIO_OFF_STATUS    = 3;
    localparam int GPIO_OFF_RISE_MASK = 4;
    localparam int GPIO_OFF_FALL_MASK = 5;

    localparam logic [GPIO_DATA_WIDTH-1:0] GPIO_RST_OUT    = '0;
    localparam logic [GPIO_DATA_WIDTH-1:0] GPIO_RST_DIR    = '0;
    localparam logic [GPIO_DATA_WIDTH-1:0] GPIO_RST_STATUS = '0;
    localparam logic [GPIO_DATA_WIDTH-1:0] GPIO_RST_MASK   = '0;
    localparam logic [GPIO_DATA_WIDTH-1:0] GPIO_RST_RDATA  = '0;

endpackage
`default_nettype wire

// File: rtl/gpio_if.sv
`default_nettype none
// ============================================================================
// Module  : gpio_if
// Brief   : Data-memory bus slice seen by the GPIO peripheral (chip-select,
//           strobes, word offset, write data and registered read data).
// Revision: 1.0 - initial release
// ============================================================================
interface gpio_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  cs;
    logic                  we;
    logic                  re;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output cs, we, re, addr, wdata,
        input  rdata
    );

    modport slave (
        input  cs, we, re, addr, wdata,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : gpio_sync_edge
// Brief   : Per-bit multi-flop input synchroniser with a one-cycle delayed
//           copy for rising/falling edge detection.
// Revision: 1.0 - initial release
// ============================================================================
module gpio_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Stage 0 samples the asynchronous pins; the top stage is the clean copy.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;
    logic [WIDTH-1:0]                  r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage <= '0;
            r_prev  <= '0;
        end else begin
            r_stage <= {r_stage[SYNC_STAGES-2:0], pins};
            r_prev  <= r_stage[SYNC_STAGES-1];
        end
    end

    assign sync = r_stage[SYNC_STAGES-1];
    assign rise = sync & ~r_prev;
    assign fall = ~sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/gpio_port.sv
`default_nettype none
// ============================================================================
// Module  : gpio_port
// Brief   : Memory-mapped GPIO with output/direction registers, synchronised
//           inputs, masked sticky edge status (W1C) and a level interrupt.
//           Build option GPIO_READBACK_MIX_EN: IN returns OUT for driven bits.
// Revision: 1.0 - initial release
// ============================================================================
module gpio_port
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH  = GPIO_DATA_WIDTH,
    parameter int ADDR_WIDTH  = GPIO_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    gpio_if.slave                 bus,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_status;
    logic [DATA_WIDTH-1:0] r_rise_mask;
    logic [DATA_WIDTH-1:0] r_fall_mask;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_irq;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_sync;
    logic [DATA_WIDTH-1:0] w_rise;
    logic [DATA_WIDTH-1:0] w_fall;
    logic [DATA_WIDTH-1:0] w_in_view;
    logic [DATA_WIDTH-1:0] w_set;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_addr = bus.addr;
    assign w_wr   = bus.cs & bus.we;
    assign w_rd   = bus.cs & bus.re;

    gpio_sync_edge #(
        .WIDTH       (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .pins  (gpio_in),
        .sync  (w_sync),
        .rise  (w_rise),
        .fall  (w_fall)
    );

`ifdef GPIO_READBACK_MIX_EN
    assign w_in_view = (w_sync & ~r_dir) | (r_out & r_dir);
`else
    assign w_in_view = w_sync;
`endif

    // Edge detection always watches the raw synchronised pins.
    assign w_set = (w_rise & r_rise_mask) | (w_fall & r_fall_mask);

    always_comb begin
        w_clr = '0;
        if (w_wr && (int'(w_addr) == GPIO_OFF_STATUS)) begin
            w_clr = bus.wdata;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (int'(w_addr))
            GPIO_OFF_OUT:       w_rd_mux = r_out;
            GPIO_OFF_DIR:       w_rd_mux = r_dir;
            GPIO_OFF_IN:        w_rd_mux = w_in_view;
            GPIO_OFF_STATUS:    w_rd_mux = r_status;
            GPIO_OFF_RISE_MASK: w_rd_mux = r_rise_mask;
            GPIO_OFF_FALL_MASK: w_rd_mux = r_fall_mask;
            default:            w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out       <= DATA_WIDTH'(GPIO_RST_OUT);
            r_dir       <= DATA_WIDTH'(GPIO_RST_DIR);
            r_rise_mask <= DATA_WIDTH'(GPIO_RST_MASK);
            r_fall_mask <= DATA_WIDTH'(GPIO_RST_MASK);
        end else if (w_wr) begin
            case (int'(w_addr))
                GPIO_OFF_OUT:       r_out       <= bus.wdata;
                GPIO_OFF_DIR:       r_dir       <= bus.wdata;
                GPIO_OFF_RISE_MASK: r_rise_mask <= bus.wdata;
                GPIO_OFF_FALL_MASK: r_fall_mask <= bus.wdata;
                default: ;
            endcase
        end
    end

    // A set event in the same cycle as a W1C clear keeps the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_status <= DATA_WIDTH'(GPIO_RST_STATUS);
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_set;
            r_irq    <= |r_status;
        end
    end

    // Read data samples pre-write register state and holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= DATA_WIDTH'(GPIO_RST_RDATA);
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign bus.rdata = r_rdata;
    assign gpio      = r_out;
    assign gpio_oe   = r_dir;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpio_port
// Brief   : Self-checking bench for gpio_port: cycle-level behavioural model
//           plus directed vectors with hand-computed expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpio_port;

    localparam int SYNC_STAGES = 2;

    logic        clk;
    logic        reset;
    logic [31:0] gpio_in;
    logic [31:0] gpio;
    logic [31:0] gpio_oe;
    logic        irq;

    int n_cmp;
    int n_err;

    gpio_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    gpio_port #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .gpio_in (gpio_in),
        .gpio    (gpio),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the edge detector and IN register see the pin value sampled
    // SYNC_STAGES edges earlier; m_hist[0] is the most recent sample.
    logic [31:0] m_out, m_dir, m_status, m_rmask, m_fmask, m_rdata;
    logic        m_irq;
    logic [31:0] m_hist [0:SYNC_STAGES];

    task automatic model_reset();
        m_out = 0; m_dir = 0; m_status = 0; m_rmask = 0; m_fmask = 0;
        m_rdata = 0; m_irq = 0;
        for (int i = 0; i <= SYNC_STAGES; i++) m_hist[i] = 0;
    endtask

    task automatic model_step();
        logic [31:0] now_v, before_v, set_v, clr_v, in_v;
        now_v    = m_hist[SYNC_STAGES-1];
        before_v = m_hist[SYNC_STAGES];
        set_v    = (now_v & ~before_v & m_rmask) | (~now_v & before_v & m_fmask);
`ifdef GPIO_READBACK_MIX_EN
        in_v = (now_v & ~m_dir) | (m_out & m_dir);
`else
        in_v = now_v;
`endif
        clr_v = 0;
        if (bus.cs && bus.re) begin
            case (int'(bus.addr))
                0: m_rdata = m_out;
                1: m_rdata = m_dir;
                2: m_rdata = in_v;
                3: m_rdata = m_status;
                4: m_rdata = m_rmask;
                5: m_rdata = m_fmask;
                default: m_rdata = 0;
            endcase
        end
        if (bus.cs && bus.we) begin
            case (int'(bus.addr))
                0: m_out   = bus.wdata;
                1: m_dir   = bus.wdata;
                3: clr_v   = bus.wdata;
                4: m_rmask = bus.wdata;
                5: m_fmask = bus.wdata;
                default: ;
            endcase
        end
        m_irq    = (m_status != 0);
        m_status = (m_status & ~clr_v) | set_v;
        for (int i = SYNC_STAGES; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = gpio_in;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        check("gpio",    gpio,         m_out);
        check("gpio_oe", gpio_oe,      m_dir);
        check("irq",     32'(irq),     32'(m_irq));
        check("rdata",   bus.rdata,    m_rdata);
    end

    task automatic bus_write(input int off, input logic [31:0] d);
        bus.cs = 1; bus.we = 1; bus.re = 0; bus.addr = 3'(off); bus.wdata = d;
        @(negedge clk);
        bus.cs = 0; bus.we = 0;
    endtask

    task automatic bus_read(input int off, output logic [31:0] d);
        bus.cs = 1; bus.we = 0; bus.re = 1; bus.addr = 3'(off);
        @(negedge clk);
        bus.cs = 0; bus.re = 0;
        d = bus.rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        n_cmp = 0; n_err = 0;
        reset = 0; gpio_in = 0;
        bus.cs = 0; bus.we = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_gpio", gpio, 32'h0);
        check("rst_oe", gpio_oe, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1;
        @(negedge clk);

        bus_write(0, 32'hFFFF_FFFF);
        bus_write(1, 32'h0000_FFFF);
        check("wr_gpio", gpio, 32'hFFFF_FFFF);
        check("wr_oe", gpio_oe, 32'h0000_FFFF);
        bus_read(0, rd);
        check("rd_out", rd, 32'hFFFF_FFFF);

        bus_write(0, 32'h0000_00FF);
        bus_write(1, 32'h0000_00FF);
        gpio_in = 32'h00FF_0000;
        repeat (3) @(negedge clk);
        bus_read(2, rd);
`ifdef GPIO_READBACK_MIX_EN
        check("rd_in", rd, 32'h00FF_00FF);
`else
        check("rd_in", rd, 32'h00FF_0000);
`endif

        // Rise on bit 0: flag at the third edge, irq one edge later.
        bus_write(4, 32'h0000_0001);
        gpio_in = 32'h00FF_0001;
        repeat (3) @(negedge clk);
        check("irq_pre", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'h1);
        bus_read(3, rd);
        check("st_rise", rd, 32'h0000_0001);
        bus_write(3, 32'h0000_0001);
        @(negedge clk);
        check("irq_clr", 32'(irq), 32'h0);
        bus_read(3, rd);
        check("st_clr", rd, 32'h0);

        // Fall on bit 31, then a W1C landing on the same edge as a new fall.
        bus_write(5, 32'h8000_0000);
        gpio_in[31] = 1'b1;
        repeat (4) @(negedge clk);
        gpio_in[31] = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(3, rd);
        check("st_fall", rd, 32'h8000_0000);
        gpio_in[31] = 1'b1;
        repeat (4) @(negedge clk);
        gpio_in[31] = 1'b0;
        repeat (2) @(negedge clk);
        bus_write(3, 32'h8000_0000);
        bus_read(3, rd);
        check("st_collide", rd, 32'h8000_0000);
        check("irq_collide", 32'(irq), 32'h1);

        // Same-offset write and read returns the pre-write value.
        bus.cs = 1; bus.we = 1; bus.re = 1; bus.addr = 3'd0; bus.wdata = 32'h0000_700A;
        @(negedge clk);
        bus.cs = 0; bus.we = 0; bus.re = 0;
        check("rw_old", bus.rdata, 32'h0000_00FF);
        check("rw_gpio", gpio, 32'h0000_700A);

        // Deselected access is ignored.
        bus.cs = 0; bus.we = 1; bus.re = 1; bus.addr = 3'd0; bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.we = 0; bus.re = 0;
        check("nocs_gpio", gpio, 32'h0000_700A);
        check("nocs_rdata", bus.rdata, 32'h0000_00FF);

        bus_write(6, 32'hDEAD_BEEF);
        bus_read(6, rd);  check("rd_res6", rd, 32'h0);
        bus_read(7, rd);  check("rd_res7", rd, 32'h0);
        bus_read(0, rd);  check("keep_out", rd, 32'h0000_700A);
        bus_read(1, rd);  check("keep_dir", rd, 32'h0000_00FF);
        bus_read(4, rd);  check("keep_rm", rd, 32'h0000_0001);
        bus_read(5, rd);  check("keep_fm", rd, 32'h8000_0000);
        bus_read(3, rd);  check("keep_st", rd, 32'h8000_0000);

        // Reset in the middle of a read.
        bus.cs = 1; bus.re = 1; bus.addr = 3'd0;
        #2 reset = 0;
        #1;
        check("mid_rdata", bus.rdata, 32'h0);
        check("mid_gpio", gpio, 32'h0);
        check("mid_oe", gpio_oe, 32'h0);
        check("mid_irq", 32'(irq), 32'h0);
        @(negedge clk);
        bus.cs = 0; bus.re = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        bus_read(0, rd);
        check("post_out", rd, 32'h0);
        repeat (4) @(negedge clk);
        check("post_irq", 32'(irq), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Memory-mapped GPIO peripheral on the CPU data-memory bus. It drives the 32-bit `gpio` pins that the CPU bench checks after store instructions.
- Holds output data and direction registers.
- Synchronises the input pins and captures rising/falling edges into a sticky status register for an interrupt line.
- Decodes a small word-addressed register window; the CPU core selects it via chip-select.

Parameters:
- DATA_WIDTH, 32, width of bus data and of the GPIO pin vector.
- ADDR_WIDTH, 3, word-offset width of the register window.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  peripheral select from CPU address decode.
- we  in  1  write strobe; qualified by cs.
- re  in  1  read strobe; qualified by cs.
- addr  in  ADDR_WIDTH  word offset.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  registered read data.
- gpio_in  in  DATA_WIDTH  asynchronous pin inputs.
- gpio  out  DATA_WIDTH  output data register value.
- gpio_oe  out  DATA_WIDTH  per-bit output enable; 1 = drive.
- irq  out  1  level interrupt, registered.

Behaviour:
- Register map (word offsets):
  - 0 OUT (RW)
  - 1 DIR (RW)
  - 2 IN (RO, synchronised pins)
  - 3 STATUS (RW1C edge flags)
  - 4 RISE_MASK (RW)
  - 5 FALL_MASK (RW)
  - 6–7 reserved: reads return 0, writes ignored.
- Reset (reset=0, async): gpio=0, gpio_oe=0, rdata=0, irq=0. OUT, DIR, STATUS, both masks, synchroniser flops and previous-sample register all 0.
- Writes: take effect at the clk edge where cs&we=1. gpio/gpio_oe reflect a new OUT/DIR value in the cycle after the write edge (zero added latency beyond the register).
- Reads:
  - rdata is updated at the edge where cs&re=1; valid the following cycle (1-cycle latency, matches data RAM).
  - rdata holds its value when no read occurs.
  - Simultaneous we&re to the same offset returns the pre-write value.
- Input synchroniser: SYNC_STAGES flops per bit. IN reads the last stage. prev holds last stage delayed one cycle.
- Edge detect, per bit:
  - rise = sync & ~prev; fall = ~sync & prev.
  - STATUS[i] is set on (rise[i]&RISE_MASK[i]) | (fall[i]&FALL_MASK[i]).
  - Detection runs regardless of DIR.
- STATUS W1C: a write clears the bits where wdata=1. If a set event and a clear hit the same bit in the same cycle, the set wins (bit stays 1).
- irq = |STATUS, registered; asserts one cycle after the STATUS bit sets.
- Latency from a gpio_in toggle to the STATUS bit: SYNC_STAGES+1 edges. For example, a rise before edge N sets STATUS at edge N+2 with the default depth.
- Pin high out of reset: prev=0, so a rising edge is recorded if RISE_MASK is already set. Masks are 0 after reset, so no spurious flag.
- Reset asserted mid-operation clears everything immediately. A pending read is lost and rdata=0.
- Bus accesses with cs=0 have no effect.

Optional Feature:
- GPIO_READBACK_MIX_EN
  - Defined: IN reads (sync & ~DIR) | (OUT & DIR), so output bits read back the driven value.
  - Undefined: IN reads the raw synchronised pins for all bits.
  - Edge detection always uses raw synchronised pins in both builds.

Decomposition:
- Shared package `gpio_pkg`:
  - register offset constants GPIO_OFF_OUT … GPIO_OFF_FALL_MASK
  - DATA_WIDTH default
  - reset value constants
- One natural sub-module, `gpio_sync_edge`: per-vector SYNC_STAGES synchroniser plus prev register. Outputs sync, rise, fall.
- Register file and read mux stay in `gpio_port`.

Test Plan:
- Reset then write OUT=0xFFFFFFFF, DIR=0x0000FFFF → next cycle gpio=0xFFFFFFFF, gpio_oe=0x0000FFFF. Read OUT → rdata=0xFFFFFFFF one cycle after the read.
- gpio_in=0x00FF0000 held 3 cycles, read IN → rdata=0x00FF0000. Build with GPIO_READBACK_MIX_EN, OUT=0xFF, DIR=0xFF → rdata=0x00FF00FF.
- RISE_MASK=0x1, drive gpio_in[0] 0→1 → STATUS=0x1 at edge +3 and irq=1 one cycle later. Write STATUS=0x1 → STATUS=0, irq=0.
- FALL_MASK=0x80000000, drop gpio_in[31] in the same cycle as a W1C write of 0x80000000 lands on an existing flag → bit remains 1.
- Write 0xDEADBEEF to offset 6 → read offset 6 returns 0, all other registers unchanged.
- Assert reset during a read with OUT=0x700A → rdata=0, gpio=0, gpio_oe=0, irq=0 immediately. After release, read OUT → 0.
